branch_resolve_ctrl: RTL and testbench

- Sequencer for the branch comparator in the RV32I core.
- Accepts one branch/jump from the execute stage and drives the comparator's unsigned-select input. It samples the equal/less-than results, decides taken/not-taken, computes the target and handshakes a redirect to fetch. It then holds the pipeline flush for a fixed number of cycles.
- Only one branch is in flight at a time. The upstream stage stalls while the unit is busy.

---
 rtl/rv32i_pkg.sv | 21 ++
 rtl/br_target_gen.sv | 26 ++
 rtl/branch_resolve_ctrl.sv | 150 +++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I branch resolution logic: funct3 encodings,
// sequencer state encoding and the default datapath width.
package rv32i_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESOLVE  = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_FLUSH    = 2'd3
    } br_state_t;

endpackage

// File: rtl/br_target_gen.sv
// Branch/jump target adder: pc + imm, or (rs1 + imm) with bit 0 cleared for JALR.
// Flags targets that are not 4-byte aligned (bit 1 set).
module br_target_gen
    import rv32i_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            is_jalr,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;

    always_comb begin
        base = is_jalr ? rs1 : pc;
        sum  = base + imm;
        target = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
        misalign = target[1];
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Sequences one branch/jump at a time through the comparator, issues the fetch
// redirect for taken branches and then holds the pipeline flush.
module branch_resolve_ctrl
    import rv32i_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_funct3,
    input  logic             br_is_jal,
    input  logic             br_is_jalr,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [XLEN-1:0]  br_imm,
    input  logic [XLEN-1:0]  br_rs1,
    output logic             cmp_un,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic             stall,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             misalign,
    output logic             illegal_br,
    input  logic             kill,
    output logic [CNT_W-1:0] stat_br,
    output logic [CNT_W-1:0] stat_taken
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    br_state_t       state, state_next;
    logic [2:0]      funct3_q;
    logic            jal_q, jalr_q;
    logic [XLEN-1:0] pc_q, imm_q, rs1_q, target_q;
    logic [3:0]      flush_cnt;

    logic [XLEN-1:0] target;
    logic            target_misalign;
    logic            cond_taken, is_illegal, taken;

    br_target_gen #(.XLEN(XLEN)) u_target (
        .pc       (pc_q),
        .imm      (imm_q),
        .rs1      (rs1_q),
        .is_jalr  (jalr_q),
        .target   (target),
        .misalign (target_misalign)
    );

    // Comparator flags are only meaningful while in RESOLVE, where this is consumed.
    always_comb begin
        cond_taken = 1'b0;
        is_illegal = 1'b0;
        case (funct3_q)
            F3_BEQ:           cond_taken = cmp_eq;
            F3_BNE:           cond_taken = !cmp_eq;
            F3_BLT, F3_BLTU:  cond_taken = cmp_lt && !cmp_eq;
            F3_BGE, F3_BGEU:  cond_taken = cmp_eq || !cmp_lt;
            default:          is_illegal = 1'b1;
        endcase
        if (jal_q || jalr_q) is_illegal = 1'b0;
        taken = jal_q || jalr_q || cond_taken;
    end

    always_comb begin
        state_next     = state;
        br_ready       = 1'b0;
        stall          = 1'b0;
        cmp_un         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        flush          = 1'b0;
        misalign       = 1'b0;
        illegal_br     = 1'b0;
        case (state)
            ST_IDLE: begin
                br_ready = 1'b1;
                if (br_valid && !kill) state_next = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                stall  = 1'b1;
                cmp_un = funct3_q[1];
                if (kill) begin
                    state_next = ST_IDLE;
                end else begin
                    misalign   = taken && target_misalign;
                    illegal_br = is_illegal;
                    state_next = (taken && !target_misalign) ? ST_REDIRECT : ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                stall          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                if (kill)                state_next = ST_IDLE;
                else if (redirect_ready) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                stall = 1'b1;
                flush = 1'b1;
                if (kill || flush_cnt == 4'd1) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            funct3_q   <= '0;
            jal_q      <= 1'b0;
            jalr_q     <= 1'b0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            target_q   <= '0;
            flush_cnt  <= '0;
            stat_br    <= '0;
            stat_taken <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && br_valid && !kill) begin
                funct3_q <= br_funct3;
                jal_q    <= br_is_jal;
                jalr_q   <= br_is_jalr;
                pc_q     <= br_pc;
                imm_q    <= br_imm;
                rs1_q    <= br_rs1;
            end
            // Statistics only count resolutions that were not aborted by kill.
            if (state == ST_RESOLVE && !kill) begin
                target_q <= target;
                if (stat_br != {CNT_W{1'b1}}) stat_br <= stat_br + 1'b1;
                if (taken && !target_misalign && stat_taken != {CNT_W{1'b1}})
                    stat_taken <= stat_taken + 1'b1;
            end
            if (state == ST_REDIRECT && redirect_ready && !kill)
                flush_cnt <= FLUSH_LOAD;
            else if (state == ST_FLUSH)
                flush_cnt <= flush_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed vector table, randomized
// branches against a reference model, and kill/reset corner sequences.
module tb_branch_resolve_ctrl;

    localparam int XLEN         = 32;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             br_valid, br_ready;
    logic [2:0]       br_funct3;
    logic             br_is_jal, br_is_jalr;
    logic [XLEN-1:0]  br_pc, br_imm, br_rs1;
    logic             cmp_un, cmp_eq, cmp_lt;
    logic             stall, redirect_valid, redirect_ready;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush, misalign, illegal_br, kill;
    logic [CNT_W-1:0] stat_br, stat_taken;

    int checks = 0;
    int errors = 0;
    int exp_br = 0;
    int exp_taken = 0;

    typedef struct {
        logic [2:0]  funct3;
        logic        is_jal;
        logic        is_jalr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        eq;
        logic        lt;
        logic        exp_un;
        logic        exp_redir;
        logic        exp_mis;
        logic        exp_ill;
        logic [31:0] exp_pc;
        int          ready_wait;
    } vec_t;

    vec_t vectors[10];

    branch_resolve_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .br_valid(br_valid), .br_ready(br_ready), .br_funct3(br_funct3),
        .br_is_jal(br_is_jal), .br_is_jalr(br_is_jalr),
        .br_pc(br_pc), .br_imm(br_imm), .br_rs1(br_rs1),
        .cmp_un(cmp_un), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .flush(flush), .misalign(misalign),
        .illegal_br(illegal_br), .kill(kill),
        .stat_br(stat_br), .stat_taken(stat_taken)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkCounters();
        checkOutput("stat_br", 32'(stat_br), 32'(exp_br));
        checkOutput("stat_taken", 32'(stat_taken), 32'(exp_taken));
    endtask

    task automatic presentBranch(input logic [2:0] f3, input logic jal, input logic jalr,
                                 input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
        br_valid   = 1'b1;
        br_funct3  = f3;
        br_is_jal  = jal;
        br_is_jalr = jalr;
        br_pc      = pc;
        br_imm     = imm;
        br_rs1     = rs1;
    endtask

    // Runs one branch from acceptance to return to IDLE, checking every cycle.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        checkOutput("br_ready_idle", 32'(br_ready), 32'd1);
        presentBranch(v.funct3, v.is_jal, v.is_jalr, v.pc, v.imm, v.rs1);
        @(negedge clk);
        br_valid = 1'b0;
        cmp_eq = v.eq;
        cmp_lt = v.lt;
        #1;
        checkOutput("resolve_stall", 32'(stall), 32'd1);
        checkOutput("resolve_br_ready", 32'(br_ready), 32'd0);
        checkOutput("cmp_un", 32'(cmp_un), 32'(v.exp_un));
        checkOutput("illegal_br", 32'(illegal_br), 32'(v.exp_ill));
        checkOutput("misalign", 32'(misalign), 32'(v.exp_mis));
        @(negedge clk);
        cmp_eq = 1'b0;
        cmp_lt = 1'b0;
        #1;
        if (v.exp_redir) begin
            for (int i = 0; i <= v.ready_wait; i++) begin
                checkOutput("redirect_valid", 32'(redirect_valid), 32'd1);
                checkOutput("redirect_pc", redirect_pc, v.exp_pc);
                checkOutput("redirect_stall", 32'(stall), 32'd1);
                checkOutput("redirect_no_flush", 32'(flush), 32'd0);
                if (i == v.ready_wait) redirect_ready = 1'b1;
                @(negedge clk);
                redirect_ready = 1'b0;
                #1;
            end
            for (int i = 0; i < FLUSH_CYCLES; i++) begin
                checkOutput("flush_high", 32'(flush), 32'd1);
                checkOutput("flush_stall", 32'(stall), 32'd1);
                checkOutput("flush_redirect_low", 32'(redirect_valid), 32'd0);
                @(negedge clk);
                #1;
            end
            exp_taken++;
        end
        exp_br++;
        checkOutput("done_br_ready", 32'(br_ready), 32'd1);
        checkOutput("done_flush", 32'(flush), 32'd0);
        checkOutput("done_stall", 32'(stall), 32'd0);
        checkOutput("done_redirect_valid", 32'(redirect_valid), 32'd0);
        checkOutput("done_pulses", 32'({illegal_br, misalign}), 32'd0);
        checkCounters();
    endtask

    // Reference model: decides from operand values and RISC-V branch semantics.
    task automatic buildRandom(output vec_t v);
        logic [31:0] a, b;
        logic        taken;
        int          kind;
        kind = $urandom_range(3);
        v.is_jal  = (kind == 0);
        v.is_jalr = (kind == 1);
        v.funct3  = 3'($urandom_range(7));
        v.pc      = $urandom & 32'hFFFF_FFFC;
        v.imm     = $urandom & 32'hFFFF_FFFE;
        v.rs1     = $urandom;
        a = $urandom;
        b = ($urandom_range(2) == 0) ? a : $urandom;
        v.exp_un = v.funct3[1];
        v.eq = (a == b);
        v.lt = v.exp_un ? (a < b) : ($signed(a) < $signed(b));
        case (v.funct3)
            3'd0:    taken = (a == b);
            3'd1:    taken = (a != b);
            3'd4:    taken = $signed(a) < $signed(b);
            3'd5:    taken = $signed(a) >= $signed(b);
            3'd6:    taken = a < b;
            3'd7:    taken = a >= b;
            default: taken = 1'b0;
        endcase
        if (v.is_jal || v.is_jalr) taken = 1'b1;
        v.exp_pc    = v.is_jalr ? ((v.rs1 + v.imm) & 32'hFFFF_FFFE) : (v.pc + v.imm);
        v.exp_mis   = taken && v.exp_pc[1];
        v.exp_redir = taken && !v.exp_pc[1];
        v.exp_ill   = !(v.is_jal || v.is_jalr) && (v.funct3 == 3'd2 || v.funct3 == 3'd3);
        v.ready_wait = $urandom_range(2);
    endtask

    task automatic goToRedirect();
        @(negedge clk);
        presentBranch(3'b000, 1'b0, 1'b0, 32'h800, 32'h40, 32'h0);
        @(negedge clk);
        br_valid = 1'b0;
        cmp_eq = 1'b1;
        @(negedge clk);
        cmp_eq = 1'b0;
        exp_br++;
        exp_taken++;
        #1;
        checkOutput("seq_redirect_valid", 32'(redirect_valid), 32'd1);
    endtask

    initial begin
        vec_t v;
        //                funct3 jal jalr pc            imm           rs1           eq lt un redir mis ill exp_pc        wait
        vectors[0] = '{3'b000, 1'b0, 1'b0, 32'h100,  32'h20,       32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h120,  0};
        vectors[1] = '{3'b110, 1'b0, 1'b0, 32'h200,  32'h40,       32'h0,    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h240,  0};
        vectors[2] = '{3'b101, 1'b0, 1'b0, 32'h300,  32'h10,       32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h310,  0};
        vectors[3] = '{3'b101, 1'b0, 1'b0, 32'h300,  32'h10,       32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    0};
        vectors[4] = '{3'b000, 1'b0, 1'b1, 32'h400,  32'h4,        32'h2001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2004, 0};
        vectors[5] = '{3'b000, 1'b1, 1'b0, 32'h0,    32'h6,        32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    0};
        vectors[6] = '{3'b010, 1'b0, 1'b0, 32'h500,  32'h8,        32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,    0};
        vectors[7] = '{3'b001, 1'b0, 1'b0, 32'h1000, 32'hFFFF_FFF0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFF0,  5};
        vectors[8] = '{3'b100, 1'b0, 1'b0, 32'h600,  32'h8,        32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    0};
        vectors[9] = '{3'b111, 1'b0, 1'b0, 32'h700,  32'h8,        32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    0};

        rst_n = 1'b0;
        br_valid = 1'b0; br_funct3 = '0; br_is_jal = 1'b0; br_is_jalr = 1'b0;
        br_pc = '0; br_imm = '0; br_rs1 = '0;
        cmp_eq = 1'b0; cmp_lt = 1'b0; redirect_ready = 1'b0; kill = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_br_ready", 32'(br_ready), 32'd1);
        checkOutput("reset_outputs", 32'({stall, redirect_valid, flush, misalign, illegal_br, cmp_un}), 32'd0);
        checkOutput("reset_redirect_pc", redirect_pc, 32'd0);
        checkCounters();
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 10; i++) applyStimulus(vectors[i]);

        $display("[TB] randomized branches");
        for (int i = 0; i < 60; i++) begin
            buildRandom(v);
            applyStimulus(v);
        end

        $display("[TB] kill together with redirect_ready");
        goToRedirect();
        kill = 1'b1;
        redirect_ready = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        redirect_ready = 1'b0;
        #1;
        checkOutput("kill_redirect_idle", 32'(br_ready), 32'd1);
        checkOutput("kill_redirect_flush", 32'(flush), 32'd0);
        checkOutput("kill_redirect_valid", 32'(redirect_valid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("kill_redirect_flush_later", 32'(flush), 32'd0);
        checkCounters();

        $display("[TB] kill during resolve");
        @(negedge clk);
        presentBranch(3'b000, 1'b0, 1'b0, 32'h900, 32'h2, 32'h0);
        @(negedge clk);
        br_valid = 1'b0;
        cmp_eq = 1'b1;
        kill = 1'b1;
        #1;
        checkOutput("kill_resolve_no_misalign", 32'(misalign), 32'd0);
        @(negedge clk);
        kill = 1'b0;
        cmp_eq = 1'b0;
        #1;
        checkOutput("kill_resolve_idle", 32'(br_ready), 32'd1);
        checkOutput("kill_resolve_no_redirect", 32'(redirect_valid), 32'd0);
        checkCounters();

        $display("[TB] kill in idle with br_valid");
        @(negedge clk);
        presentBranch(3'b000, 1'b1, 1'b0, 32'h0, 32'h8, 32'h0);
        kill = 1'b1;
        @(negedge clk);
        br_valid = 1'b0;
        kill = 1'b0;
        #1;
        checkOutput("kill_idle_not_accepted", 32'(br_ready), 32'd1);
        checkOutput("kill_idle_no_stall", 32'(stall), 32'd0);

        $display("[TB] reset during flush");
        goToRedirect();
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        #1;
        checkOutput("pre_reset_flush", 32'(flush), 32'd1);
        rst_n = 1'b0;
        exp_br = 0;
        exp_taken = 0;
        #1;
        checkOutput("reset_flush_outputs", 32'({stall, redirect_valid, flush, misalign, illegal_br}), 32'd0);
        checkOutput("reset_flush_br_ready", 32'(br_ready), 32'd1);
        checkCounters();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(vectors[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
